// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bundle of the PISO serializer.
// The slave side is the serializer; the master side is its upstream producer and serial consumer.
interface piso_serializer_if #(
  parameter int W = 4
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_last;
  logic         busy;

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Double-buffered PISO: W-bit words in over valid/ready, MSB-first serial out, first bit 1 clock after accept.
// Backpressure: din_ready falls only while the holding register is full; back-to-back words stream gap-free.
module piso_serializer #(
  parameter int   W          = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic xfer;
  logic last_bit;

  assign bus.din_ready = ~hold_full_q;
  assign xfer          = bus.din_valid & ~hold_full_q;
  assign last_bit      = (state_q == SHIFT) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sreg_d  = bus.din;
          cnt_d   = CNT_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_d = {sreg_q[W-2:0], 1'b0};
          cnt_d  = cnt_q - 1'b1;
          if (xfer) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // xfer cannot fire here: din_ready is low while the hold slot is occupied
          sreg_d      = hold_q;
          cnt_d       = CNT_TOP;
          hold_full_d = 1'b0;
        end else if (xfer) begin
          sreg_d = bus.din;
          cnt_d  = CNT_TOP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sout       = (state_q == SHIFT) ? sreg_q[W-1] : IDLE_LEVEL;
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout_last  = last_bit;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed vector tables, a chained 4-bit SIPO,
// reset-mid-word and idle-level sequences, then random traffic against a bit-queue model.
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_serializer_if #(.W(W)) bus ();
  piso_serializer_if #(.W(W)) bus1 ();

  piso_serializer #(.W(W), .IDLE_LEVEL(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  piso_serializer #(.W(W), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Downstream 4-bit SIPO: shifts sout in every clock, newest bit at the LSB.
  logic [3:0] sipo_q;
  always @(posedge clk) sipo_q <= {sipo_q[2:0], bus.sout};

  int checks = 0;
  int failures = 0;

  // Expected outputs packed as {sout, sout_valid, sout_last, din_ready, busy}.
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [4:0] e;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {bus.sout, bus.sout_valid, bus.sout_last, bus.din_ready, bus.busy};
  endfunction

  function automatic void add(input logic v, input logic [3:0] d, input logic [4:0] e);
    vec_t t;
    t.v = v; t.d = d; t.e = e;
    tbl.push_back(t);
  endfunction

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("%s[%0d]", name, i), 32'(outs()), 32'(tbl[i].e));
      bus.din_valid = tbl[i].v;
      bus.din       = tbl[i].d;
      tick();
    end
    bus.din_valid = 1'b0;
    tbl.delete();
  endtask

  initial begin
    int nbits, first_c, last_c, sent;
    bit done4, done8;
    logic [3:0] rd;
    logic rv, xfer;
    bit bitq[$];

    bus.din = '0;
    bus.din_valid = 1'b0;
    bus1.din = '0;
    bus1.din_valid = 1'b0;

    #1;
    chk("reset_outs", 32'(outs()), 32'(5'b00010));
    chk("reset_idle1", 32'({bus1.sout, bus1.sout_valid, bus1.busy}), 32'(3'b100));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_outs", 32'(outs()), 32'(5'b00010));

    // Single word 1011
    add(1, 4'hB, 5'b00010);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b11111);
    add(0, 4'h0, 5'b00010);
    run_tbl("single");

    // Chained SIPO: 4'hB then 4'h6 with din_valid held high until both are taken
    nbits = 0; first_c = -1; last_c = -1; sent = 0; done4 = 0; done8 = 0;
    bus.din = 4'hB;
    bus.din_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (nbits == 4 && !done4) begin
        chk("sipo_B", 32'(sipo_q), 32'h0B);
        done4 = 1;
      end
      if (nbits == 8 && !done8) begin
        chk("sipo_6", 32'(sipo_q), 32'h06);
        done8 = 1;
      end
      if (bus.sout_valid) begin
        nbits++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus.din_valid && bus.din_ready) sent++;
      tick();
      if (sent == 1) bus.din = 4'h6;
      if (sent >= 2) bus.din_valid = 1'b0;
    end
    chk("sipo_nbits", 32'(nbits), 32'd8);
    chk("sipo_contig", 32'(last_c - first_c + 1), 32'd8);
    chk("sipo_seen8", 32'(done8), 32'd1);

    // Back-pressure: three words on consecutive cycles
    add(1, 4'h1, 5'b00010);
    add(1, 4'h2, 5'b01011);
    add(1, 4'h3, 5'b01001);
    add(1, 4'h3, 5'b01001);
    add(1, 4'h3, 5'b11101);
    add(1, 4'h3, 5'b01011);
    add(0, 4'h0, 5'b01001);
    add(0, 4'h0, 5'b11001);
    add(0, 4'h0, 5'b01101);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b11111);
    add(0, 4'h0, 5'b00010);
    run_tbl("bpress");

    // Accept in the last-bit cycle with the hold slot empty: ready never drops
    add(1, 4'hF, 5'b00010);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b11011);
    add(1, 4'h5, 5'b11111);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b11111);
    add(0, 4'h0, 5'b00010);
    run_tbl("lastacc");

    // Reset after two bits of 4'hA, then a clean 4'hC
    bus.din = 4'hA;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs()), 32'(5'b00010));
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_release", 32'(outs()), 32'(5'b00010));
    tick();
    chk("midrst_nopartial", 32'(outs()), 32'(5'b00010));
    add(1, 4'hC, 5'b00010);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b11011);
    add(0, 4'h0, 5'b01011);
    add(0, 4'h0, 5'b01111);
    add(0, 4'h0, 5'b00010);
    run_tbl("afterrst");

    // IDLE_LEVEL=1 instance with no traffic
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle1[%0d]", i), 32'({bus1.sout, bus1.sout_valid}), 32'(2'b10));
    end

    // Random traffic vs. a queue of bits still to be emitted (front = bit on sout now)
    for (int c = 0; c < 400; c++) begin
      logic [4:0] exp;
      exp[4] = (bitq.size() > 0) ? bitq[0] : 1'b0;
      exp[3] = (bitq.size() > 0);
      exp[2] = (bitq.size() % W) == 1;
      exp[1] = (bitq.size() <= W);
      exp[0] = (bitq.size() > 0);
      chk($sformatf("rand[%0d]", c), 32'(outs()), 32'(exp));
      rv = ($urandom_range(0, 9) < 6);
      rd = 4'($urandom);
      xfer = rv && (bitq.size() <= W);
      bus.din_valid = rv;
      bus.din = rd;
      tick();
      if (bitq.size() > 0) void'(bitq.pop_front());
      if (xfer)
        for (int b = W - 1; b >= 0; b--) bitq.push_back(rd[b]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: the upstream stage that drives the serial input of the 4-bit serial-in/parallel-out register.
- Accepts W-bit words over a valid/ready handshake.
- Shifts each word out MSB first, one bit per clock, on a single serial line.
- Double-buffered so back-to-back words stream with no idle cycle.
- MSB-first order means that after W clocks the downstream SIPO's parallel output equals the transmitted word.

Parameters:
- W, 4, word width in bits; legal range 2..32.
- IDLE_LEVEL, 1'b0, value driven on sout while no word is being shifted.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  W  parallel word to send.
- din_valid  in  1  din holds a word to send.
- din_ready  out  1  block can take a word this cycle.
- sout  out  1  serial data; feeds the SIPO din.
- sout_valid  out  1  sout carries a data bit this cycle.
- sout_last  out  1  sout carries bit 0 (the final bit) of the current word.
- busy  out  1  shifter active or holding register full.

Behaviour:
- Reset (async assert, sync release):
  - Shifter idle; holding register empty; bit counter = 0.
  - sout = IDLE_LEVEL, sout_valid = 0, sout_last = 0, busy = 0.
  - din_ready = 1 once rst_n is high.
  - Reset mid-word discards the word in flight and any held word; no partial bits are emitted after release.
- Handshake:
  - A transfer occurs at a rising edge where din_valid && din_ready.
  - din_ready = !hold_full. It is combinational from registered state only, never from din_valid.
  - din/din_valid may change freely when no transfer occurs.
- State machine:
  - IDLE: sout = IDLE_LEVEL, sout_valid = 0.
  - SHIFT: shift register drives sout = sreg[W-1]; bit counter runs W-1 down to 0.
- Accept while IDLE:
  - The word loads directly into the shifter at that edge; holding register stays empty.
  - The next cycle shows sout = din[W-1], sout_valid = 1. Latency is 1 clock from the accepting edge to the first bit.
- Accept while in SHIFT:
  - If this is not the last-bit cycle, the word goes into the holding register (hold_full = 1, din_ready drops next cycle).
  - If this is the last-bit cycle and the holding register is empty, the word loads directly into the shifter. The output runs with no gap.
- Last-bit cycle (counter = 0, sout_last = 1), at the closing edge:
  - If hold_full: the holding register moves into the shifter, hold_full clears, and state stays SHIFT. The next cycle is bit W-1 of the new word; there are no bubbles.
  - Else if a transfer is occurring: load directly, as above.
  - Else: go to IDLE.
- Shifting: each non-last edge left-shifts sreg by 1 (zero fill) and decrements the counter.
- sout_valid is high for exactly W consecutive cycles per word.
- sout_last is high only in the cycle with counter = 0, i.e. the W-th bit.
- busy = (state == SHIFT) || hold_full.
- Sustained throughput is 1 word per W clocks. At most 2 words are in flight (shifter + hold). A third is back-pressured.
- All outputs are registered or decoded from registers; there are no combinational paths from din/din_valid to any output.

Test Plan:
1. Reset, then W=4, din=4'b1011 with valid for one cycle at edge 0.
   - Required: din_ready=1 at edge 0.
   - Cycles 1-4: sout = 1,0,1,1 with sout_valid=1; sout_last only in cycle 4.
   - Cycle 5: sout=0, sout_valid=0, busy=0.
2. Chain the output into the 4-bit SIPO and send 4'hB, then 4'h6 with din_valid held high.
   - Required: SIPO pout = 4'hB after the 4th bit edge and 4'h6 exactly 4 edges later.
   - sout_valid stays high for 8 contiguous cycles.
3. Back-pressure: present 3 words 4'h1, 4'h2, 4'h3 on consecutive cycles.
   - Required: the first two are accepted; din_ready=0 from the cycle after the second accept until the last-bit edge of 4'h1.
   - 4'h3 is then accepted, and the serial stream shows 0001 0010 0011 with no gap.
4. Accept on the last-bit cycle with the holding register empty: send 4'hF, then present 4'h5 exactly in its sout_last cycle.
   - Required: the stream reads 1111 0101 contiguously; hold_full is never set.
5. Reset mid-word: start 4'hA, assert rst_n low after 2 bits, then release.
   - Required: immediately sout=IDLE_LEVEL, sout_valid=0, busy=0, din_ready=1.
   - The next word 4'hC is emitted cleanly as 1100.
6. IDLE_LEVEL=1, no traffic for 10 cycles.
   - Required: sout=1 and sout_valid=0 throughout.
